// File: rtl/result_display_if.sv
// result_display bus: held result in, multiplexed
// 7-segment drive and conversion status out.
interface result_display_if;
  logic [7:0] Value;
  logic [6:0] Seg;
  logic [2:0] An;
  logic       Busy;

  modport master (
    output Value,
    input  Seg,
    input  An,
    input  Busy
  );

  modport slave (
    input  Value,
    output Seg,
    output An,
    output Busy
  );
endinterface

// File: rtl/result_display.sv
// 8-bit result to 3-digit BCD via double-dabble, shown on a
// scanned common-anode 7-segment display with zero blanking.
module result_display #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic             clock,
  input  logic             reset_n,
  result_display_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  localparam logic [15:0] DIV_MAX = 16'(SCAN_DIV - 1);

  state_t      state, state_n;
  logic [7:0]  last, last_n;
  logic [7:0]  src, src_n;
  logic [19:0] shreg, shreg_n;
  logic [19:0] adj;
  logic [2:0]  cnt, cnt_n;
  logic [11:0] digits, digits_n;

  logic [15:0] div;
  logic [1:0]  idx;
  logic [3:0]  nib;
  logic        blank;
  logic [6:0]  seg, seg_n;
  logic [2:0]  an, an_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      last   <= '0;
      src    <= '0;
      shreg  <= '0;
      cnt    <= '0;
      digits <= '0;
    end else begin
      state  <= state_n;
      last   <= last_n;
      src    <= src_n;
      shreg  <= shreg_n;
      cnt    <= cnt_n;
      digits <= digits_n;
    end
  end

  // add-3 correction on each BCD nibble before the shift
  always_comb begin
    adj = shreg;
    if (shreg[19:16] >= 4'd5)
      adj[19:16] = shreg[19:16] + 4'd3;
    if (shreg[15:12] >= 4'd5)
      adj[15:12] = shreg[15:12] + 4'd3;
    if (shreg[11:8] >= 4'd5)
      adj[11:8] = shreg[11:8] + 4'd3;
  end

  always_comb begin
    state_n  = state;
    last_n   = last;
    src_n    = src;
    shreg_n  = shreg;
    cnt_n    = cnt;
    digits_n = digits;
    unique case (state)
      IDLE: begin
        if (bus.Value != last) begin
          shreg_n = {12'd0, bus.Value};
          src_n   = bus.Value;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        shreg_n = {adj[18:0], 1'b0};
        cnt_n   = cnt + 3'd1;
        if (cnt == 3'd7)
          state_n = COMMIT;
      end
      COMMIT: begin
        digits_n = shreg[19:8];
        last_n   = src;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.Busy = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
      idx <= '0;
    end else if (div == DIV_MAX) begin
      div <= '0;
      idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end else begin
      div <= div + 16'd1;
    end
  end

  always_comb begin
    nib   = digits[3:0];
    blank = 1'b0;
    unique case (1'b1)
      idx == 2'd0: begin
        nib   = digits[3:0];
        blank = 1'b0;
      end
      idx == 2'd1: begin
        nib   = digits[7:4];
        blank = (digits[11:4] == 8'd0);
      end
      idx == 2'd2: begin
        nib   = digits[11:8];
        blank = (digits[11:8] == 4'd0);
      end
      default: begin
        nib   = 4'd0;
        blank = 1'b1;
      end
    endcase
  end

  always_comb begin
    seg_n = 7'b1111111;
    unique case (nib)
      4'd0:    seg_n = 7'b1000000;
      4'd1:    seg_n = 7'b1111001;
      4'd2:    seg_n = 7'b0100100;
      4'd3:    seg_n = 7'b0110000;
      4'd4:    seg_n = 7'b0011001;
      4'd5:    seg_n = 7'b0010010;
      4'd6:    seg_n = 7'b0000010;
      4'd7:    seg_n = 7'b1111000;
      4'd8:    seg_n = 7'b0000000;
      4'd9:    seg_n = 7'b0010000;
      default: seg_n = 7'b1111111;
    endcase
    an_n = 3'b111;
    if (!blank)
      an_n = ~(3'b001 << idx);
    else
      seg_n = 7'b1111111;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seg <= 7'b1111111;
      an  <= 3'b111;
    end else begin
      seg <= seg_n;
      an  <= an_n;
    end
  end

  assign bus.Seg = seg;
  assign bus.An  = an;

endmodule

// File: tb/tb_result_display.sv
// Scoreboard bench for result_display: queued expected conversions
// checked on Busy fall, display checked every cycle.
module tb_result_display;

  localparam int SD = 4;

  typedef struct {
    logic [7:0]  val;
    logic [11:0] bcd;
  } exp_t;

  logic clock;
  logic reset_n;
  result_display_if bus ();

  result_display #(.SCAN_DIV(SD)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          k = 0;
  logic        prev_busy = 1'b0;
  int          blen = 0;
  logic [11:0] md = '0;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // edges seen since reset release
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) k <= 0;
    else          k <= k + 1;
  end

  always @(negedge clock) begin
    int          ix;
    logic [3:0]  d;
    logic        bl;
    logic [6:0]  es;
    logic [2:0]  ea;
    exp_t        e;
    if (!reset_n || k == 0) begin
      chk("reset_seg",  bus.Seg,  7'h7f);
      chk("reset_an",   bus.An,   3'b111);
      chk("reset_busy", bus.Busy, 0);
      if (!reset_n) begin
        md        = '0;
        prev_busy = 1'b0;
        blen      = 0;
      end
    end else begin
      ix = ((k - 1) / SD) % 3;
      case (ix)
        0:       begin d = md[3:0];  bl = 1'b0; end
        1:       begin d = md[7:4];  bl = (md[11:4] == 8'd0); end
        default: begin d = md[11:8]; bl = (md[11:8] == 4'd0); end
      endcase
      es = bl ? 7'b1111111 : glyph(d);
      ea = bl ? 3'b111 : ~(3'b001 << ix);
      chk("disp_seg", bus.Seg, es);
      chk("disp_an",  bus.An,  ea);
      if (bus.Busy) blen++;
      if (prev_busy && !bus.Busy) begin
        if (q.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("busy_len", blen, 9);
          chk("digits", dut.digits, e.bcd);
          md = e.bcd;
        end
        blen = 0;
      end
      prev_busy = bus.Busy;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic conv(input logic [7:0] v, input logic [11:0] b);
    exp_t e;
    e.val = v;
    e.bcd = b;
    q.push_back(e);
    bus.Value = v;
  endtask

  initial begin
    reset_n   = 1'b0;
    bus.Value = 8'd0;
    tick(3);
    reset_n = 1'b1;
    tick(14);

    conv(8'd255, 12'h255);
    tick(26);
    conv(8'd7, 12'h007);
    tick(26);
    conv(8'd100, 12'h100);
    tick(26);
    conv(8'd42, 12'h042);
    tick(3);
    conv(8'd99, 12'h099);
    tick(36);
    conv(8'd200, 12'h200);
    tick(4);
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(30);
    conv(8'd0, 12'h000);
    tick(26);

    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
